soc_ctrl_clk_rst_delay_gen: RTL and testbench

Power-on/reset sequencer for one SoC sub-domain. When the local reset request releases, the block waits DELAY_CYCLES and then releases the domain reset. It waits a further DELAY_CYCLES before passing the clock enable through. It also drives a glitch-free gated copy of its clock. It sits in soc_ctrl, between the global reset/clock source and each gated domain.

---
 rtl/soc_ctrl_clk_rst_delay_gen.sv | 104 ++++++++++
 tb/tb_soc_ctrl_clk_rst_delay_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/soc_ctrl_clk_rst_delay_gen.sv
// Reset/clock-enable sequencer for one gated SoC sub-domain.
// Releases the domain reset, then the clock enable, each after DELAY_CYCLES, and drives an ICG clock.
module soc_ctrl_clk_rst_delay_gen #(
  parameter int unsigned DELAY_CYCLES = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arst_ni,
  input  logic clk_en_i,
  output logic clk_o,
  output logic arst_no,
  output logic clk_en_o
);

  localparam int unsigned CW = $clog2(DELAY_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(DELAY_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RST_DLY,
    CLK_DLY,
    RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          s1;
  logic          s2;
  logic          latch_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= arst_ni;
      s2 <= s1;
    end
  end

  // A falling synchronized request wins over any counter terminal match.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      count    <= '0;
      arst_no  <= 1'b0;
      clk_en_o <= 1'b0;
    end else if (!s2) begin
      state    <= IDLE;
      count    <= '0;
      arst_no  <= 1'b0;
      clk_en_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= RST_DLY;
          count    <= '0;
          arst_no  <= 1'b0;
          clk_en_o <= 1'b0;
        end
        RST_DLY: begin
          clk_en_o <= 1'b0;
          if (count == TERM) begin
            state   <= CLK_DLY;
            count   <= '0;
            arst_no <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        CLK_DLY: begin
          arst_no  <= 1'b1;
          clk_en_o <= 1'b0;
          if (count == TERM) begin
            state <= RUN;
            count <= '0;
          end else begin
            count <= count + CW'(1);
          end
        end
        RUN: begin
          arst_no  <= 1'b1;
          clk_en_o <= clk_en_i;
        end
        default: begin
          state    <= IDLE;
          count    <= '0;
          arst_no  <= 1'b0;
          clk_en_o <= 1'b0;
        end
      endcase
    end
  end

  // Enable only changes while clk_i is low, so clk_o emits whole high pulses.
  always_latch begin
    if (!clk_i) begin
      latch_q = clk_en_o;
    end
  end

  assign clk_o = clk_i & latch_q;

endmodule

// File: tb/tb_soc_ctrl_clk_rst_delay_gen.sv
// Scoreboard bench: the stimulus process queues expected outputs per edge, a monitor pops and compares.
// Unit 0 runs DELAY_CYCLES=50, unit 1 runs DELAY_CYCLES=1.
module tb_soc_ctrl_clk_rst_delay_gen;

  logic clk;
  logic rst50, a50, en50;
  logic rst1, a1, en1;
  logic gclk50, arst50, cen50;
  logic gclk1, arst1, cen1;
  int   cyc;
  int   checks;
  int   fails;

  typedef struct {
    int    edge_n;
    int    unit;
    int    kind;
    logic  arst;
    logic  en;
    logic  gclk;
    string name;
  } exp_t;

  exp_t sb[$];

  soc_ctrl_clk_rst_delay_gen #(.DELAY_CYCLES(50)) dut50 (
    .clk_i(clk), .rst_i(rst50), .arst_ni(a50), .clk_en_i(en50),
    .clk_o(gclk50), .arst_no(arst50), .clk_en_o(cen50)
  );

  soc_ctrl_clk_rst_delay_gen #(.DELAY_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .arst_ni(a1), .clk_en_i(en1),
    .clk_o(gclk1), .arst_no(arst1), .clk_en_o(cen1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push0(input int unit, input int e, input logic ar, input logic en, input string name);
    exp_t x;
    x.edge_n = e; x.unit = unit; x.kind = 0; x.arst = ar; x.en = en; x.gclk = 1'b0; x.name = name;
    sb.push_back(x);
  endtask

  task automatic push1(input int unit, input int e, input logic g, input string name);
    exp_t x;
    x.edge_n = e; x.unit = unit; x.kind = 1; x.arst = 1'b0; x.en = 1'b0; x.gclk = g; x.name = name;
    sb.push_back(x);
  endtask

  // Release sequence derived from the E0 timeline of the sequencer.
  task automatic expect_seq(input int unit, input int e0, input int d);
    push0(unit, e0 + 2, 1'b0, 1'b0, "seq_start");
    push0(unit, e0 + d + 1, 1'b0, 1'b0, "arst_still_low");
    push0(unit, e0 + d + 2, 1'b1, 1'b0, "arst_rise");
    push0(unit, e0 + 2 * d + 2, 1'b1, 1'b0, "en_still_low");
    push0(unit, e0 + 2 * d + 3, 1'b1, 1'b1, "en_rise");
    push1(unit, e0 + 2 * d + 3, 1'b0, "gclk_still_low");
    push1(unit, e0 + 2 * d + 4, 1'b1, "gclk_first_pulse");
  endtask

  task automatic applyStimulus(input int unit, input logic r, input logic a, input logic en);
    if (unit == 0) begin
      rst50 = r; a50 = a; en50 = en;
    end else begin
      rst1 = r; a1 = a; en1 = en;
    end
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic checkOutput(input exp_t x);
    logic ar, en, g;
    ar = (x.unit == 0) ? arst50 : arst1;
    en = (x.unit == 0) ? cen50 : cen1;
    g  = (x.unit == 0) ? gclk50 : gclk1;
    checks++;
    if (x.kind == 0) begin
      if ({ar, en} !== {x.arst, x.en}) begin
        fails++;
        $display("[TB] FAIL %s unit%0d edge %0d: arst_no/clk_en_o got %b%b expected %b%b",
                 x.name, x.unit, x.edge_n, ar, en, x.arst, x.en);
      end
    end else begin
      if (g !== x.gclk) begin
        fails++;
        $display("[TB] FAIL %s unit%0d edge %0d: clk_o got %b expected %b",
                 x.name, x.unit, x.edge_n, g, x.gclk);
      end
    end
  endtask

  task automatic scan(input int kind);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].kind == kind && sb[i].edge_n == cyc) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end else if (sb[i].edge_n < cyc) begin
        checks++;
        fails++;
        $display("[TB] FAIL %s unit%0d: expectation for edge %0d never checked", sb[i].name, sb[i].unit,
                 sb[i].edge_n);
        sb.delete(i);
      end
    end
  endtask

  // Monitor: gated clock sampled just after the rising edge, registered outputs on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      scan(1);
      @(negedge clk);
      scan(0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached at edge %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0, e1, e2, t, u, v, w, x;
    checks = 0;
    fails  = 0;
    applyStimulus(0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) push0(0, k, 1'b0, 1'b0, "rst_hold");
    for (int k = 2; k <= 6; k++) push1(0, k, 1'b0, "rst_gclk_low");
    push0(1, 3, 1'b0, 1'b0, "rst_hold_d1");

    wait_edge(5);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    wait_edge(7);
    applyStimulus(0, 1'b0, 1'b1, 1'b1);
    e0 = 8;
    expect_seq(0, e0, 50);
    push1(0, e0 + 60, 1'b0, "gclk_low_in_dly");

    t = e0 + 110;
    push0(0, t, 1'b1, 1'b1, "run_en");
    for (int k = 1; k <= 3; k++) push0(0, t + k, 1'b1, 1'b0, "en_drop");
    push0(0, t + 4, 1'b1, 1'b1, "en_restore");
    push1(0, t + 1, 1'b1, "gclk_before_drop");
    for (int k = 2; k <= 4; k++) push1(0, t + k, 1'b0, "gclk_drop");
    push1(0, t + 5, 1'b1, "gclk_restore");
    wait_edge(t);
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    wait_edge(t + 3);
    applyStimulus(0, 1'b0, 1'b1, 1'b1);

    u = t + 10;
    push0(0, u, 1'b1, 1'b1, "pre_rst_pulse");
    push0(0, u + 1, 1'b0, 1'b0, "rst_pulse");
    push1(0, u + 2, 1'b0, "gclk_after_rst");
    wait_edge(u);
    applyStimulus(0, 1'b1, 1'b1, 1'b1);
    wait_edge(u + 1);
    applyStimulus(0, 1'b0, 1'b1, 1'b1);
    e0 = u + 2;
    expect_seq(0, e0, 50);

    v = e0 + 110;
    push0(0, v + 2, 1'b1, 1'b1, "req_drop_sync");
    push0(0, v + 3, 1'b0, 1'b0, "req_drop_idle");
    push1(0, v + 4, 1'b0, "gclk_req_drop");
    wait_edge(v);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    wait_edge(v + 5);
    applyStimulus(0, 1'b0, 1'b1, 1'b1);
    e0 = v + 6;
    e1 = e0 + 32;
    push0(0, e0 + 31, 1'b0, 1'b0, "glitch_in_rst_dly");
    push0(0, e0 + 52, 1'b0, 1'b0, "no_early_release");
    expect_seq(0, e1, 50);
    wait_edge(e0 + 29);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    wait_edge(e0 + 31);
    applyStimulus(0, 1'b0, 1'b1, 1'b1);

    w = e1 + 110;
    push0(1, w, 1'b0, 1'b0, "d1_rst_hold");
    wait_edge(w);
    applyStimulus(1, 1'b0, 1'b1, 1'b1);
    e0 = w + 1;
    expect_seq(1, e0, 1);

    x = e0 + 10;
    push0(1, x + 2, 1'b1, 1'b1, "d1_req_drop_sync");
    push0(1, x + 3, 1'b0, 1'b0, "d1_req_drop_idle");
    wait_edge(x);
    applyStimulus(1, 1'b0, 1'b0, 1'b1);
    wait_edge(x + 5);
    applyStimulus(1, 1'b0, 1'b1, 1'b1);
    e2 = x + 6;
    push0(1, e2 + 3, 1'b0, 1'b0, "d1_drop_beats_term");
    push0(1, e2 + 4, 1'b0, 1'b0, "d1_stay_idle");
    push0(1, e2 + 8, 1'b0, 1'b0, "d1_idle_late");
    wait_edge(e2);
    applyStimulus(1, 1'b0, 1'b0, 1'b1);

    wait_edge(e2 + 12);
    foreach (sb[i]) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s unit%0d: leftover expectation for edge %0d", sb[i].name, sb[i].unit,
               sb[i].edge_n);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
